// File: rtl/saradc_pkg.sv
// SAR ADC sequencer shared definitions: state encoding, result width,
// accumulator width and ADC reset pulse length.
package saradc_pkg;

  localparam int RES_W    = 10;
  localparam int ACC_W    = 12;
  localparam int ARST_LEN = 4;
  localparam int CNT_W    = 16;

  typedef enum logic [2:0] {
    ST_ARST,
    ST_CAL,
    ST_IDLE,
    ST_CONV,
    ST_CAPT
  } state_e;

  // Sticky flag update: a set event wins over a clear in the same cycle.
  function automatic logic sticky_next(input logic q, input logic set, input logic clr);
    return set | (q & ~clr);
  endfunction

endpackage

// File: rtl/saradc_res_fifo.sv
// Result FIFO for the SAR ADC sequencer. DEPTH must be a power of two (>= 2).
// The head word is registered; a push into a full FIFO is dropped and
// reported on ovf_evt_o unless a pop happens in the same cycle.
module saradc_res_fifo
  import saradc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = RES_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] head_o,
  output logic             ovf_evt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_C = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE_C  = (AW + 1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             full, empty, do_push, do_pop;

  assign full      = (count_q == FULL_C);
  assign empty     = (count_q == '0);
  assign do_pop    = pop_i & ~empty;
  assign do_push   = push_i & (~full | do_pop);
  assign ovf_evt_o = push_i & full & ~do_pop;
  assign valid_o   = ~empty;
  assign head_o    = head_q;

  // Pointer, occupancy, storage and next-head computation.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + ONE_C;
    end else if (!do_push && do_pop) begin
      count_d = count_q - ONE_C;
    end
    // New entry becomes the head when it lands exactly at the next read slot.
    if (count_d == '0) begin
      head_d = head_q;
    end else if (do_push && (wr_ptr_q == rd_ptr_d)) begin
      head_d = push_data_i;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/saradc_seq.sv
// SAR ADC sequencer: ADC reset pulse, calibration, single/continuous
// conversions with timeout, and a result FIFO with sticky status flags.
// Optional build macro SARADC_SEQ_AVG_EN: each FIFO entry is the mean of four
// consecutive conversions, and one start request runs all four.
//
// state | meaning
// ARST  | adc_rstn_o low for ARST_LEN clocks
// CAL   | adc_en_o and adc_cal_o high for CAL_CYCLES clocks
// IDLE  | waiting for calibration, start or period tick
// CONV  | adc_en_o high, waiting for synced valid edge or timeout
// CAPT  | one clock, sample pushed toward the FIFO
module saradc_seq
  import saradc_pkg::*;
#(
  parameter int CAL_CYCLES = 64,
  parameter int TIMEOUT    = 255,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start_i,
  input  logic             cont_i,
  input  logic [15:0]      period_i,
  input  logic             cal_req_i,
  input  logic             clr_i,
  output logic             adc_rstn_o,
  output logic             adc_en_o,
  output logic             adc_cal_o,
  input  logic             adc_valid_i,
  input  logic [RES_W-1:0] adc_result_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [RES_W-1:0] res_data_o,
  output logic             busy_o,
  output logic             timeout_o,
  output logic             ovf_o
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               por_q, por_d;
  logic               start_pend_q, start_pend_d;
  logic               cal_pend_q, cal_pend_d;
  logic               tick_pend_q, tick_pend_d;
  logic [15:0]        per_cnt_q, per_cnt_d;
  logic [2:0]         vs_q, vs_d;
  logic               timeout_q, timeout_d;
  logic               ovf_q, ovf_d;
  logic               tick, adc_evt, timeout_evt, capt, burst_active;
  logic               push, ovf_evt;
  logic [RES_W-1:0]   push_data;

  assign adc_rstn_o = (state_q != ST_ARST);
  assign adc_en_o   = (state_q == ST_CAL) || (state_q == ST_CONV);
  assign adc_cal_o  = (state_q == ST_CAL);
  assign busy_o     = (state_q != ST_IDLE);
  assign timeout_o  = timeout_q;
  assign ovf_o      = ovf_q;
  assign capt       = (state_q == ST_CAPT);

  // Two-flop synchronizer plus one history flop for rising-edge detection.
  assign vs_d    = {vs_q[1:0], adc_valid_i};
  assign adc_evt = vs_q[1] & ~vs_q[2];

  // Continuous-mode period down-counter; reloads on each tick.
  always_comb begin
    tick      = 1'b0;
    per_cnt_d = per_cnt_q;
    if (!cont_i) begin
      per_cnt_d = '0;
    end else if (per_cnt_q <= 16'd1) begin
      tick      = 1'b1;
      per_cnt_d = period_i;
    end else begin
      per_cnt_d = per_cnt_q - 16'd1;
    end
  end

  // Next-state logic, request latching and state timers.
  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    por_d        = por_q;
    start_pend_d = start_pend_q | start_i;
    cal_pend_d   = cal_pend_q | cal_req_i;
    tick_pend_d  = cont_i & (tick_pend_q | tick);
    timeout_evt  = 1'b0;
    case (state_q)
      ST_ARST: begin
        if (cnt_q == CNT_W'(ARST_LEN - 1)) begin
          state_d = por_q ? ST_CAL : ST_IDLE;
          por_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CAL: begin
        if (cnt_q == CNT_W'(CAL_CYCLES - 1)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_IDLE: begin
        if (cal_pend_d) begin
          state_d    = ST_CAL;
          cal_pend_d = 1'b0;
        end else if (burst_active) begin
          state_d = ST_CONV;
        end else if (start_pend_d || tick_pend_d) begin
          state_d      = ST_CONV;
          start_pend_d = 1'b0;
          tick_pend_d  = 1'b0;
        end
      end
      ST_CONV: begin
        if (adc_evt) begin
          state_d = ST_CAPT;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          timeout_evt = 1'b1;
          state_d     = ST_ARST;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CAPT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_ARST;
      end
    endcase
  end

`ifdef SARADC_SEQ_AVG_EN
  logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
  logic [1:0]       avg_cnt_q, avg_cnt_d;

  assign acc_sum      = acc_q + ACC_W'(adc_result_i);
  assign burst_active = (avg_cnt_q != 2'd0);

  // Four-sample accumulator; the fourth capture pushes the truncated mean.
  always_comb begin
    acc_d     = acc_q;
    avg_cnt_d = avg_cnt_q;
    push      = 1'b0;
    push_data = acc_sum[ACC_W-1:2];
    if (timeout_evt) begin
      acc_d     = '0;
      avg_cnt_d = '0;
    end else if (capt) begin
      if (avg_cnt_q == 2'd3) begin
        push      = 1'b1;
        acc_d     = '0;
        avg_cnt_d = '0;
      end else begin
        acc_d     = acc_sum;
        avg_cnt_d = avg_cnt_q + 2'd1;
      end
    end
  end

  // Accumulator registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      acc_q     <= '0;
      avg_cnt_q <= '0;
    end else begin
      acc_q     <= acc_d;
      avg_cnt_q <= avg_cnt_d;
    end
  end
`else
  assign burst_active = 1'b0;
  assign push         = capt;
  assign push_data    = adc_result_i;
`endif

  assign timeout_d = sticky_next(timeout_q, timeout_evt, clr_i);
  assign ovf_d     = sticky_next(ovf_q, ovf_evt, clr_i);

  // Sequencer state, timers, pending requests, synchronizer and flags.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q      <= ST_ARST;
      cnt_q        <= '0;
      por_q        <= 1'b1;
      start_pend_q <= 1'b0;
      cal_pend_q   <= 1'b0;
      tick_pend_q  <= 1'b0;
      per_cnt_q    <= '0;
      vs_q         <= '0;
      timeout_q    <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      por_q        <= por_d;
      start_pend_q <= start_pend_d;
      cal_pend_q   <= cal_pend_d;
      tick_pend_q  <= tick_pend_d;
      per_cnt_q    <= per_cnt_d;
      vs_q         <= vs_d;
      timeout_q    <= timeout_d;
      ovf_q        <= ovf_d;
    end
  end

  saradc_res_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (RES_W)
  ) u_fifo (
    .clk_i       (wb_clk_i),
    .rst_i       (wb_rst_i),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (res_valid_o & res_ready_i),
    .valid_o     (res_valid_o),
    .head_o      (res_data_o),
    .ovf_evt_o   (ovf_evt)
  );

endmodule

// File: tb/tb_saradc_seq.sv
// Testbench for saradc_seq: directed sequences with a result scoreboard.
module tb_saradc_seq;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        cont_i = 1'b0;
  logic [15:0] period_i = '0;
  logic        cal_req_i = 1'b0;
  logic        clr_i = 1'b0;
  logic        adc_valid_i = 1'b0;
  logic [9:0]  adc_result_i = '0;
  logic        res_ready_i = 1'b0;
  logic        adc_rstn_o, adc_en_o, adc_cal_o;
  logic        res_valid_o, busy_o, timeout_o, ovf_o;
  logic [9:0]  res_data_o;

  int          checks = 0;
  int          errors = 0;
  logic [9:0]  exp_q[$];

  saradc_seq dut (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_i     (wb_rst_i),
    .start_i      (start_i),
    .cont_i       (cont_i),
    .period_i     (period_i),
    .cal_req_i    (cal_req_i),
    .clr_i        (clr_i),
    .adc_rstn_o   (adc_rstn_o),
    .adc_en_o     (adc_en_o),
    .adc_cal_o    (adc_cal_o),
    .adc_valid_i  (adc_valid_i),
    .adc_result_i (adc_result_i),
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready_i),
    .res_data_o   (res_data_o),
    .busy_o       (busy_o),
    .timeout_o    (timeout_o),
    .ovf_o        (ovf_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  // Result monitor: every accepted FIFO word is compared against the queue.
  always @(negedge wb_clk_i) begin
    if (!wb_rst_i && res_valid_o && res_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got 'h%0h, expected no result", res_data_o);
      end else begin
        if (res_data_o !== exp_q[0]) begin
          errors++;
          $display("FAIL result_data: got 'h%0h, expected 'h%0h", res_data_o, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge wb_clk_i);
    #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    step(1);
    start_i = 1'b0;
  endtask

  task automatic wait_conv(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (adc_en_o && adc_rstn_o && !adc_cal_o) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  // Waits for CONV, answers after dly clocks, holds valid for 5 clocks.
  task automatic adc_respond(input int dly, input logic [9:0] val);
    bit ok;
    wait_conv(ok);
    check("conv_entered", int'(ok), 1);
    if (ok) begin
      step(dly);
      #2;
      adc_result_i = val;
      adc_valid_i  = 1'b1;
      repeat (5) @(posedge wb_clk_i);
      #1;
      adc_valid_i = 1'b0;
    end
  endtask

  initial begin
    int  n;
    bit  found;

    // Reset values.
    step(2);
    check("rst_adc_rstn", int'(adc_rstn_o), 0);
    check("rst_adc_en", int'(adc_en_o), 0);
    check("rst_adc_cal", int'(adc_cal_o), 0);
    check("rst_busy", int'(busy_o), 1);
    check("rst_res_valid", int'(res_valid_o), 0);
    check("rst_res_data", int'(res_data_o), 0);
    check("rst_timeout", int'(timeout_o), 0);
    check("rst_ovf", int'(ovf_o), 0);

    // Power-on: 4 clocks ADC reset, 64 clocks calibration, then idle.
    wb_rst_i = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge wb_clk_i);
      if (!adc_rstn_o) n++;
      else break;
    end
    check("por_arst_len", n, 4);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (adc_cal_o) n++;
      else break;
      @(negedge wb_clk_i);
    end
    check("por_cal_len", n, 64);
    check("por_idle", int'(busy_o), 0);
    @(posedge wb_clk_i);
    #1;

`ifdef SARADC_SEQ_AVG_EN
    // One start runs four conversions; their mean is a single entry.
    res_ready_i = 1'b1;
    exp_q.push_back(10'h101);
    pulse_start();
    for (int k = 0; k < 4; k++) adc_respond(6, 10'(10'h100 + k));
    step(3);
    check("avg_idle", int'(busy_o), 0);
    check("avg_single_entry", int'(res_valid_o), 0);
`else
    // Single conversion, result 0x2A5 within 4 clocks of valid.
    res_ready_i = 1'b1;
    exp_q.push_back(10'h2A5);
    pulse_start();
    check("single_conv_en", int'(adc_en_o), 1);
    step(20);
    #2;
    adc_result_i = 10'h2A5;
    adc_valid_i  = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge wb_clk_i);
      #1;
      if (res_valid_o) begin
        found = 1'b1;
        break;
      end
    end
    check("single_latency", int'(found), 1);
    check("single_data", int'(res_data_o), 'h2A5);
    step(2);
    adc_valid_i = 1'b0;
    step(3);
    check("single_back_idle", int'(busy_o), 0);

    // Timeout: 255 clocks in CONV, 4 clocks ADC reset, idle without CAL.
    pulse_start();
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge wb_clk_i);
      if (adc_en_o && adc_rstn_o) n++;
      else break;
    end
    check("timeout_conv_len", n, 255);
    check("timeout_flag_set", int'(timeout_o), 1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!adc_rstn_o) n++;
      else break;
      @(negedge wb_clk_i);
    end
    check("timeout_arst_len", n, 4);
    check("timeout_no_cal", int'(adc_cal_o), 0);
    check("timeout_idle", int'(busy_o), 0);
    @(posedge wb_clk_i);
    #1;
    step(3);
    check("timeout_sticky", int'(timeout_o), 1);
    check("timeout_still_no_cal", int'(adc_cal_o), 0);
    clr_i = 1'b1;
    step(1);
    clr_i = 1'b0;
    check("timeout_cleared", int'(timeout_o), 0);

    // Continuous mode into a stalled sink: 4 stored, 5th overflows.
    res_ready_i = 1'b0;
    period_i    = 16'd100;
    cont_i      = 1'b1;
    for (int k = 0; k < 5; k++) begin
      adc_respond(10, 10'(10'h011 + k));
      if (k < 4) exp_q.push_back(10'(10'h011 + k));
      if (k == 3) check("ovf_not_yet", int'(ovf_o), 0);
    end
    cont_i = 1'b0;
    step(2);
    check("ovf_set", int'(ovf_o), 1);
    check("ovf_fifo_full_valid", int'(res_valid_o), 1);
    step(3);
    check("ovf_sticky", int'(ovf_o), 1);
    clr_i = 1'b1;
    step(1);
    clr_i = 1'b0;
    check("ovf_cleared", int'(ovf_o), 0);
    res_ready_i = 1'b1;
    step(6);
    check("ovf_drained", int'(res_valid_o), 0);
    check("ovf_drain_count", exp_q.size(), 0);

    // Calibration request during CONV wins over a pending start after CAPT.
    pulse_start();
    cal_req_i = 1'b1;
    step(1);
    cal_req_i = 1'b0;
    pulse_start();
    exp_q.push_back(10'h155);
    adc_respond(8, 10'h155);
    check("cal_after_capt", int'(adc_cal_o), 1);
    exp_q.push_back(10'h0AA);
    adc_respond(5, 10'h0AA);
    step(3);
    check("cal_then_conv_idle", int'(busy_o), 0);

    // Reset mid-conversion discards the sample and redoes power-on.
    pulse_start();
    step(5);
    #2;
    adc_result_i = 10'h3FF;
    adc_valid_i  = 1'b1;
    @(posedge wb_clk_i);
    #1;
    wb_rst_i = 1'b1;
    #1;
    check("midrst_busy", int'(busy_o), 1);
    check("midrst_rstn", int'(adc_rstn_o), 0);
    check("midrst_en", int'(adc_en_o), 0);
    check("midrst_res_valid", int'(res_valid_o), 0);
    step(2);
    wb_rst_i    = 1'b0;
    adc_valid_i = 1'b0;
    step(5);
    check("midrst_recal", int'(adc_cal_o), 1);
    step(70);
    check("midrst_idle", int'(busy_o), 0);
    check("midrst_no_result", int'(res_valid_o), 0);
`endif

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
